// File: rtl/mem_stage.sv
// mem_stage: EXE/MEM register, data-memory request/acknowledge with lane alignment and
// load extension, MEM/WB register. Define MEM_TIMEOUT_EN to build the bus-timeout watchdog.
module mem_stage
`ifdef MEM_TIMEOUT_EN
  #(parameter int TIMEOUT = 16)
`endif
  (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] e_result,
  input  logic [31:0] e_qb,
  input  logic [4:0]  e_rn,
  input  logic        e_wreg,
  input  logic        e_m2reg,
  input  logic        e_wmem,
  input  logic [1:0]  e_msize,
  input  logic        e_msign,
  output logic        stall,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        w_wreg,
  output logic [4:0]  w_rn,
  output logic [31:0] w_data,
  output logic        misalign,
  output logic        bus_err
  );

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1
`ifdef MEM_TIMEOUT_EN
    , S_ERR = 2'd2
`endif
  } state_t;

  state_t      state, state_next;

  logic [31:0] m_result;
  logic [31:0] m_qb;
  logic [4:0]  m_rn;
  logic        m_wreg;
  logic        m_m2reg;
  logic        m_wmem;
  logic [1:0]  m_msize;
  logic        m_msign;

  logic        mem_op;
  logic        is_half;
  logic        is_word;
  logic        mis;
  logic        misaligned_op;
  logic        in_err;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // EXE/MEM pipeline register: frozen while the memory transaction is outstanding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_result <= 32'h0;
      m_qb     <= 32'h0;
      m_rn     <= 5'd0;
      m_wreg   <= 1'b0;
      m_m2reg  <= 1'b0;
      m_wmem   <= 1'b0;
      m_msize  <= 2'b00;
      m_msign  <= 1'b0;
    end else if (!stall) begin
      m_result <= e_result;
      m_qb     <= e_qb;
      m_rn     <= e_rn;
      m_wreg   <= e_wreg;
      m_m2reg  <= e_m2reg;
      m_wmem   <= e_wmem;
      m_msize  <= e_msize;
      m_msign  <= e_msign;
    end
  end

  assign mem_op        = m_wmem | m_m2reg;
  assign is_half       = (m_msize == 2'b01);
  assign is_word       = m_msize[1];
  assign mis           = (is_half & m_result[0]) | (is_word & (m_result[1:0] != 2'b00));
  assign misaligned_op = mem_op & mis;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  logic [7:0] wait_cnt, wait_cnt_next;

  assign in_err  = (state == S_ERR);
  assign bus_err = in_err;
`else
  assign in_err  = 1'b0;
  assign bus_err = 1'b0;
`endif

  // The ack-to-stall path is combinational so an ack releases the pipeline the same cycle
  assign dm_req  = mem_op & ~mis & ~in_err;
  assign stall   = (dm_req & ~dm_ack) | in_err;
  assign dm_we   = m_wmem;
  assign dm_addr = {m_result[31:2], 2'b00};

  // Store lane replication and byte enables
  always_comb begin
    dm_be    = 4'b1111;
    dm_wdata = m_qb;
    case (m_msize)
      2'b00: begin
        dm_be    = 4'b0001 << m_result[1:0];
        dm_wdata = {4{m_qb[7:0]}};
      end
      2'b01: begin
        dm_be    = m_result[1] ? 4'b1100 : 4'b0011;
        dm_wdata = {2{m_qb[15:0]}};
      end
      default: begin
        dm_be    = 4'b1111;
        dm_wdata = m_qb;
      end
    endcase
    if (!mem_op) dm_be = 4'b0000;
  end

  // Load lane selection and sign/zero extension
  always_comb begin
    ld_byte = dm_rdata[7:0];
    case (m_result[1:0])
      2'b00:   ld_byte = dm_rdata[7:0];
      2'b01:   ld_byte = dm_rdata[15:8];
      2'b10:   ld_byte = dm_rdata[23:16];
      default: ld_byte = dm_rdata[31:24];
    endcase
    ld_half = m_result[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (m_msize)
      2'b00:   ld_ext = {{24{m_msign & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{m_msign & ld_half[15]}}, ld_half};
      default: ld_ext = dm_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (dm_req && !dm_ack) state_next = S_WAIT;
      S_WAIT: begin
        if (dm_ack) state_next = S_IDLE;
`ifdef MEM_TIMEOUT_EN
        else if (wait_cnt == LAST_WAIT) state_next = S_ERR;
`endif
      end
`ifdef MEM_TIMEOUT_EN
      S_ERR:  state_next = S_ERR;
`endif
      default: state_next = S_IDLE;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  // Counter equals the number of request cycles already spent, so the edge ending
  // request cycle TIMEOUT moves the FSM into ERR
  always_comb begin
    wait_cnt_next = 8'd0;
    if (state == S_IDLE && dm_req && !dm_ack) wait_cnt_next = 8'd1;
    else if (state == S_WAIT)                 wait_cnt_next = wait_cnt + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 8'd0;
    else     wait_cnt <= wait_cnt_next;
  end
`endif

  // MEM/WB register: bubble while stalled or when a misaligned access is squashed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_wreg   <= 1'b0;
      w_rn     <= 5'd0;
      w_data   <= 32'h0;
      misalign <= 1'b0;
    end else if (stall) begin
      w_wreg   <= 1'b0;
      w_rn     <= 5'd0;
      w_data   <= 32'h0;
      misalign <= 1'b0;
    end else if (misaligned_op) begin
      w_wreg   <= 1'b0;
      w_rn     <= 5'd0;
      w_data   <= 32'h0;
      misalign <= 1'b1;
    end else begin
      w_wreg   <= m_wreg;
      w_rn     <= m_rn;
      w_data   <= m_m2reg ? ld_ext : m_result;
      misalign <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table of single-transaction vectors plus
// hand-written sequences for late ack, back-to-back ops, reset abort and timeout.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] e_result, e_qb, dm_rdata;
  logic [4:0]  e_rn;
  logic        e_wreg, e_m2reg, e_wmem, e_msign, dm_ack;
  logic [1:0]  e_msize;
  logic        stall, dm_req, dm_we, w_wreg, misalign, bus_err;
  logic [31:0] dm_addr, dm_wdata, w_data;
  logic [3:0]  dm_be;
  logic [4:0]  w_rn;

  int total = 0;
  int bad   = 0;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .e_result(e_result), .e_qb(e_qb), .e_rn(e_rn),
    .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_wmem(e_wmem),
    .e_msize(e_msize), .e_msign(e_msign),
    .stall(stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .w_wreg(w_wreg), .w_rn(w_rn), .w_data(w_data),
    .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] qb;
    logic [4:0]  rn;
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic [1:0]  msize;
    logic        msign;
    logic [31:0] rdata;
    logic        x_req;
    logic        x_we;
    logic [3:0]  x_be;
    logic [31:0] x_addr;
    logic [31:0] x_wdata;
    logic        x_wreg;
    logic [4:0]  x_rn;
    logic [31:0] x_data;
    logic        x_mis;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] result, input logic [31:0] qb, input logic [4:0] rn,
                               input logic wreg, input logic m2reg, input logic wmem,
                               input logic [1:0] msize, input logic msign);
    e_result = result;
    e_qb     = qb;
    e_rn     = rn;
    e_wreg   = wreg;
    e_m2reg  = m2reg;
    e_wmem   = wmem;
    e_msize  = msize;
    e_msign  = msign;
  endtask

  task automatic bubble();
    applyStimulus(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string pfx);
    checkOutput({pfx, "_stall"},    {31'h0, stall},    32'h0);
    checkOutput({pfx, "_dm_req"},   {31'h0, dm_req},   32'h0);
    checkOutput({pfx, "_dm_we"},    {31'h0, dm_we},    32'h0);
    checkOutput({pfx, "_dm_be"},    {28'h0, dm_be},    32'h0);
    checkOutput({pfx, "_dm_addr"},  dm_addr,           32'h0);
    checkOutput({pfx, "_dm_wdata"}, dm_wdata,          32'h0);
    checkOutput({pfx, "_w_wreg"},   {31'h0, w_wreg},   32'h0);
    checkOutput({pfx, "_w_rn"},     {27'h0, w_rn},     32'h0);
    checkOutput({pfx, "_w_data"},   w_data,            32'h0);
    checkOutput({pfx, "_misalign"}, {31'h0, misalign}, 32'h0);
    checkOutput({pfx, "_bus_err"},  {31'h0, bus_err},  32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // result, qb, rn, wreg, m2reg, wmem, msize, msign, rdata,
    // x_req, x_we, x_be, x_addr, x_wdata, x_wreg, x_rn, x_data, x_mis
    vecs[0]  = '{32'h00001234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0,
                 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 5'd5, 32'h00001234, 1'b0};
    vecs[1]  = '{32'h00000100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'hDEADBEEF,
                 1'b1, 1'b0, 4'hF, 32'h00000100, 32'h0, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{32'h00000103, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h80123456,
                 1'b1, 1'b0, 4'h8, 32'h00000100, 32'h0, 1'b1, 5'd3, 32'hFFFFFF80, 1'b0};
    vecs[3]  = '{32'h00000103, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h80123456,
                 1'b1, 1'b0, 4'h8, 32'h00000100, 32'h0, 1'b1, 5'd3, 32'h00000080, 1'b0};
    vecs[4]  = '{32'h00000102, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h80123456,
                 1'b1, 1'b0, 4'hC, 32'h00000100, 32'h0, 1'b1, 5'd9, 32'hFFFF8012, 1'b0};
    vecs[5]  = '{32'h00000100, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h1234F00D,
                 1'b1, 1'b0, 4'h3, 32'h00000100, 32'h0, 1'b1, 5'd4, 32'h0000F00D, 1'b0};
    vecs[6]  = '{32'h00000101, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h00007F00,
                 1'b1, 1'b0, 4'h2, 32'h00000100, 32'h0, 1'b1, 5'd8, 32'h0000007F, 1'b0};
    vecs[7]  = '{32'h00000102, 32'h0000ABCD, 5'd0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0,
                 1'b1, 1'b1, 4'hC, 32'h00000100, 32'hABCDABCD, 1'b0, 5'd0, 32'h00000102, 1'b0};
    vecs[8]  = '{32'h00000201, 32'h123456A5, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0,
                 1'b1, 1'b1, 4'h2, 32'h00000200, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h00000201, 1'b0};
    vecs[9]  = '{32'h00000300, 32'hCAFEF00D, 5'd0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 32'h0,
                 1'b1, 1'b1, 4'hF, 32'h00000300, 32'hCAFEF00D, 1'b0, 5'd0, 32'h00000300, 1'b0};
    vecs[10] = '{32'h00000101, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0,
                 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1};
    vecs[11] = '{32'h00000203, 32'h00001111, 5'd0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0,
                 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1};

    rst = 1'b1;
    bubble();
    dm_rdata = 32'h0;
    dm_ack   = 1'b0;
    #12;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b0;
    step();

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].result, vecs[i].qb, vecs[i].rn, vecs[i].wreg, vecs[i].m2reg,
                    vecs[i].wmem, vecs[i].msize, vecs[i].msign);
      dm_ack = 1'b0;
      step();
      bubble();
      dm_rdata = vecs[i].rdata;
      dm_ack   = 1'b1;
      #1;
      checkOutput($sformatf("v%0d_dm_req", i), {31'h0, dm_req}, {31'h0, vecs[i].x_req});
      checkOutput($sformatf("v%0d_stall", i),  {31'h0, stall},  32'h0);
      if (vecs[i].x_req) begin
        checkOutput($sformatf("v%0d_dm_we", i),    {31'h0, dm_we}, {31'h0, vecs[i].x_we});
        checkOutput($sformatf("v%0d_dm_be", i),    {28'h0, dm_be}, {28'h0, vecs[i].x_be});
        checkOutput($sformatf("v%0d_dm_addr", i),  dm_addr,        vecs[i].x_addr);
        if (vecs[i].x_we)
          checkOutput($sformatf("v%0d_dm_wdata", i), dm_wdata, vecs[i].x_wdata);
      end
      step();
      dm_ack = 1'b0;
      checkOutput($sformatf("v%0d_w_wreg", i),   {31'h0, w_wreg},   {31'h0, vecs[i].x_wreg});
      checkOutput($sformatf("v%0d_w_rn", i),     {27'h0, w_rn},     {27'h0, vecs[i].x_rn});
      checkOutput($sformatf("v%0d_w_data", i),   w_data,            vecs[i].x_data);
      checkOutput($sformatf("v%0d_misalign", i), {31'h0, misalign}, {31'h0, vecs[i].x_mis});
      step();
      checkOutput($sformatf("v%0d_misalign_clr", i), {31'h0, misalign}, 32'h0);
      checkOutput($sformatf("v%0d_w_wreg_clr", i),   {31'h0, w_wreg},   32'h0);
    end

    // Signed byte load acknowledged three cycles late, next op held upstream
    applyStimulus(32'h00000103, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
    step();
    applyStimulus(32'h00000055, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
    #1;
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("late_stall_%0d", c),  {31'h0, stall},  32'h1);
      checkOutput($sformatf("late_req_%0d", c),    {31'h0, dm_req}, 32'h1);
      checkOutput($sformatf("late_addr_%0d", c),   dm_addr,         32'h00000100);
      checkOutput($sformatf("late_w_wreg_%0d", c), {31'h0, w_wreg}, 32'h0);
      step();
    end
    dm_rdata = 32'h80123456;
    dm_ack   = 1'b1;
    #1;
    checkOutput("late_stall_release", {31'h0, stall}, 32'h0);
    step();
    dm_ack = 1'b0;
    bubble();
    checkOutput("late_w_wreg", {31'h0, w_wreg}, 32'h1);
    checkOutput("late_w_rn",   {27'h0, w_rn},   32'd3);
    checkOutput("late_w_data", w_data,          32'hFFFFFF80);
    step();
    checkOutput("late_next_w_rn",   {27'h0, w_rn}, 32'd6);
    checkOutput("late_next_w_data", w_data,        32'h00000055);

    // Back-to-back word loads each acknowledged immediately
    applyStimulus(32'h00000400, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
    step();
    applyStimulus(32'h00000404, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
    dm_rdata = 32'h11111111;
    dm_ack   = 1'b1;
    #1;
    checkOutput("b2b_req1",  {31'h0, dm_req}, 32'h1);
    checkOutput("b2b_addr1", dm_addr,         32'h00000400);
    checkOutput("b2b_stall1", {31'h0, stall}, 32'h0);
    step();
    bubble();
    dm_rdata = 32'h22222222;
    #1;
    checkOutput("b2b_req2",  {31'h0, dm_req}, 32'h1);
    checkOutput("b2b_addr2", dm_addr,         32'h00000404);
    checkOutput("b2b_w_rn1", {27'h0, w_rn},   32'd10);
    checkOutput("b2b_w_data1", w_data,        32'h11111111);
    step();
    dm_ack = 1'b0;
    checkOutput("b2b_w_rn2",   {27'h0, w_rn}, 32'd11);
    checkOutput("b2b_w_data2", w_data,        32'h22222222);

    // Reset in the middle of an outstanding request
    applyStimulus(32'h00000500, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
    step();
    bubble();
    step();
    checkOutput("rstmid_stall_before", {31'h0, stall}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rstmid_dm_req", {31'h0, dm_req}, 32'h0);
    checkOutput("rstmid_stall",  {31'h0, stall},  32'h0);
    @(negedge clk);
    rst = 1'b0;
    dm_ack = 1'b1;
    step();
    checkOutput("rstmid_w_wreg", {31'h0, w_wreg}, 32'h0);
    checkOutput("ack_ignored_stall", {31'h0, stall}, 32'h0);
    dm_ack = 1'b0;
    step();

`ifdef MEM_TIMEOUT_EN
    // Load never acknowledged: watchdog trips after the configured request cycles
    begin
      int n;
      applyStimulus(32'h00000600, 32'h0, 5'd13, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
      step();
      bubble();
      n = 0;
      while (dm_req && n < 40) begin
        n++;
        step();
      end
      checkOutput("timeout_cycles", n, 32'd16);
      for (int c = 0; c < 3; c++) begin
        checkOutput($sformatf("timeout_bus_err_%0d", c), {31'h0, bus_err}, 32'h1);
        checkOutput($sformatf("timeout_stall_%0d", c),   {31'h0, stall},   32'h1);
        checkOutput($sformatf("timeout_req_%0d", c),     {31'h0, dm_req},  32'h0);
        checkOutput($sformatf("timeout_w_wreg_%0d", c),  {31'h0, w_wreg},  32'h0);
        step();
      end
      rst = 1'b1;
      #1;
      checkAllZero("timeout_rst");
      @(negedge clk);
      rst = 1'b0;
      step();
    end
`else
    // Without the watchdog a request waits indefinitely for its ack
    applyStimulus(32'h00000600, 32'h0, 5'd13, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
    step();
    bubble();
    for (int c = 0; c < 20; c++) begin
      checkOutput($sformatf("longwait_stall_%0d", c),   {31'h0, stall},   32'h1);
      checkOutput($sformatf("longwait_bus_err_%0d", c), {31'h0, bus_err}, 32'h0);
      step();
    end
    dm_rdata = 32'h600DF00D;
    dm_ack   = 1'b1;
    #1;
    checkOutput("longwait_release", {31'h0, stall}, 32'h0);
    step();
    dm_ack = 1'b0;
    checkOutput("longwait_w_rn",   {27'h0, w_rn}, 32'd13);
    checkOutput("longwait_w_data", w_data,        32'h600DF00D);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
